// File: rtl/spsram_ctrl_if.sv
// Request/response stream bundle between a master and spsram_ctrl.
// master drives requests and accepts responses; slave is the controller.
interface spsram_ctrl_if #(
  parameter int BW_DATA = 32,
  parameter int BW_ADDR = 5
) ();
  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [BW_ADDR-1:0] req_addr;
  logic [BW_DATA-1:0] req_wdata;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [BW_DATA-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/spsram_ctrl.sv
// Single-port SRAM initiator: registers request stream into SRAM pin commands,
// tracks reads through the 2-cycle SRAM pipe, buffers read data in a small FIFO.
// A credit counter bounds reads in flight plus buffered so the FIFO never overflows.
module spsram_ctrl #(
  parameter int BW_DATA   = 32,
  parameter int BW_ADDR   = 5,
  parameter int RSP_DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  spsram_ctrl_if.slave       bus,
  output logic               o_busy,
  output logic               o_sram_cen,
  output logic               o_sram_wen,
  output logic               o_sram_oen,
  output logic [BW_ADDR-1:0] o_sram_addr,
  output logic [BW_DATA-1:0] o_sram_wdata,
  input  logic [BW_DATA-1:0] i_sram_rdata
);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0]                    cnt;
  logic [1:0]                       vld_pipe;   // [0]=rd1 (cmd issued), [1]=rd2 (data on SRAM pins)
  logic [CW-1:0]                    wr_ptr, rd_ptr;
  logic [RSP_DEPTH-1:0][BW_DATA-1:0] mem;

  logic accept, rd_acc, pop, push, empty;

  // Ready comes only from the credit count; held low while reset is asserted.
  assign bus.req_ready = i_rstn & (cnt < CW'(RSP_DEPTH));
  assign accept        = bus.req_valid & bus.req_ready;
  assign rd_acc        = accept & ~bus.req_we;
  assign empty         = (wr_ptr == rd_ptr);
  assign bus.rsp_valid = ~empty;
  assign bus.rsp_rdata = mem[rd_ptr[PW-1:0]];
  assign pop           = bus.rsp_valid & bus.rsp_ready;
  assign push          = vld_pipe[1];
  assign o_busy        = vld_pipe[0] | vld_pipe[1] | o_sram_cen | ~empty;

  // SRAM command stage: one registered command per accepted request.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_sram_cen   <= 1'b0;
      o_sram_wen   <= 1'b0;
      o_sram_oen   <= 1'b0;
      o_sram_addr  <= '0;
      o_sram_wdata <= '0;
    end else if (accept) begin
      o_sram_cen  <= 1'b1;
      o_sram_wen  <= bus.req_we;
      o_sram_oen  <= ~bus.req_we;
      o_sram_addr <= bus.req_addr;
      if (bus.req_we) o_sram_wdata <= bus.req_wdata;
    end else begin
      o_sram_cen <= 1'b0;
      o_sram_wen <= 1'b0;
      o_sram_oen <= 1'b0;
    end
  end

  // Read valid shift register tracking the synchronous-read SRAM latency.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) vld_pipe <= '0;
    else         vld_pipe <= {vld_pipe[0], rd_acc};
  end

  // Credits: taken on read accept, returned on response pop.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt <= '0;
    end else begin
      case ({rd_acc, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Response FIFO; storage cleared on reset so rdata reads 0 out of reset.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[PW-1:0]] <= i_sram_rdata;
        wr_ptr              <= wr_ptr + CW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + CW'(1);
    end
  end
endmodule

// File: tb/tb_spsram_ctrl.sv
// Bench for spsram_ctrl: behavioural SRAM, transaction-level reference model
// (address map + queue of expected responses with arrival times), random traffic.
module tb_spsram_ctrl;
  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic        o_busy, o_sram_cen, o_sram_wen, o_sram_oen;
  logic [4:0]  o_sram_addr;
  logic [31:0] o_sram_wdata, i_sram_rdata;

  spsram_ctrl_if #(.BW_DATA(32), .BW_ADDR(5)) bus ();

  spsram_ctrl #(.BW_DATA(32), .BW_ADDR(5), .RSP_DEPTH(4)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .bus(bus), .o_busy(o_busy),
    .o_sram_cen(o_sram_cen), .o_sram_wen(o_sram_wen), .o_sram_oen(o_sram_oen),
    .o_sram_addr(o_sram_addr), .o_sram_wdata(o_sram_wdata), .i_sram_rdata(i_sram_rdata)
  );

  always #5 i_clk = ~i_clk;

  // Synchronous-read single-port SRAM.
  logic [31:0] sram_mem [32];
  always @(posedge i_clk) begin
    if (o_sram_cen) begin
      if (o_sram_wen)      sram_mem[o_sram_addr] <= o_sram_wdata;
      else if (o_sram_oen) i_sram_rdata          <= sram_mem[o_sram_addr];
    end
  end

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int n_rd_hs = 0, n_pop = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge i_clk) cyc <= cyc + 1;

  // Reference model: address map, expected responses and the edge after which each is visible.
  logic [31:0] ref_mem [32];
  logic [31:0] exp_d [$];
  int          exp_t [$];
  int          acc_e = -100, rd_e = -100;

  always @(negedge i_clk) begin
    logic m_ready, m_valid, m_busy, m_cen;
    if (!i_rstn) begin
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      chk("rst_busy",      32'(o_busy), 32'd0);
      chk("rst_sram_ctl",  32'({o_sram_cen, o_sram_wen, o_sram_oen}), 32'd0);
      chk("rst_sram_addr", 32'(o_sram_addr), 32'd0);
      chk("rst_sram_wd",   o_sram_wdata, 32'd0);
      exp_d.delete();
      exp_t.delete();
      acc_e = -100;
      rd_e  = -100;
    end else begin
      m_ready = (exp_d.size() < 4);
      m_valid = (exp_d.size() > 0) && (exp_t[0] <= cyc);
      m_cen   = (acc_e == cyc);
      m_busy  = m_cen || (rd_e == cyc - 1) || m_valid;
      chk("req_ready", 32'(bus.req_ready), 32'(m_ready));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
      chk("sram_cen",  32'(o_sram_cen), 32'(m_cen));
      chk("busy",      32'(o_busy), 32'(m_busy));
      if (m_valid) chk("rsp_rdata", bus.rsp_rdata, exp_d[0]);
      if (bus.req_valid && bus.req_ready && !bus.req_we) n_rd_hs++;
      if (bus.req_valid && m_ready) begin
        acc_e = cyc + 1;
        if (bus.req_we) ref_mem[bus.req_addr] = bus.req_wdata;
        else begin
          exp_d.push_back(ref_mem[bus.req_addr]);
          exp_t.push_back(cyc + 3);
          rd_e = cyc + 1;
        end
      end
      if (m_valid && bus.rsp_ready) begin
        void'(exp_d.pop_front());
        void'(exp_t.pop_front());
        n_pop++;
      end
    end
  end

  // Present a request and hold it until accepted; returns 1 unit after the accept edge.
  task automatic do_req(input logic we, input logic [4:0] a, input logic [31:0] d);
    bit done = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge i_clk);
      if (bus.req_ready) begin
        @(posedge i_clk);
        #1;
        done = 1;
      end
    end
    if (!done) begin
      chk("req_timeout", 32'd0, 32'd1);
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic drain();
    bit done = 0;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge i_clk);
      if (exp_d.size() == 0 && !bus.rsp_valid) done = 1;
    end
    chk("drain_done", 32'(done), 32'd1);
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    int base, p0, c0;
    bit rdone;
    // T1: reset with a request applied
    i_rstn        = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 5'd0;
    bus.req_wdata = 32'h0000_00A5;
    repeat (3) @(posedge i_clk);
    #1 i_rstn = 1'b1;
    @(negedge i_clk);
    chk("t1_ready", 32'(bus.req_ready), 32'd1);
    @(posedge i_clk);
    #1;
    chk("t1_cmd", 32'({o_sram_cen, o_sram_wen, o_sram_oen}), 32'b110);
    chk("t1_wdata", o_sram_wdata, 32'h0000_00A5);
    idle(2);

    // T2: write then read same address next cycle
    bus.rsp_ready = 1'b1;
    do_req(1'b1, 5'd3, 32'hDEAD_BEEF);
    do_req(1'b0, 5'd3, 32'd0);
    bus.req_valid = 1'b0;
    @(negedge i_clk); chk("t2_lat0", 32'(bus.rsp_valid), 32'd0);
    @(negedge i_clk); chk("t2_lat1", 32'(bus.rsp_valid), 32'd0);
    @(negedge i_clk); chk("t2_lat2", 32'(bus.rsp_valid), 32'd1);
    chk("t2_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
    drain();

    // T3: fill then stream 32 back-to-back reads
    for (int i = 0; i < 32; i++) do_req(1'b1, 5'(i), 32'(i * 32'h11));
    p0 = n_pop;
    c0 = cyc;
    for (int i = 0; i < 32; i++) do_req(1'b0, 5'(i), 32'd0);
    chk("t3_cycles", 32'(cyc - c0), 32'd32);
    drain();
    chk("t3_pops", 32'(n_pop - p0), 32'd32);

    // Random traffic with random response backpressure
    rdone = 0;
    fork
      begin
        repeat (300) begin
          do_req(1'($urandom_range(0, 1)), 5'($urandom), $urandom);
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        bus.req_valid = 1'b0;
        rdone = 1;
      end
      begin
        while (!rdone) begin
          @(posedge i_clk);
          #1 bus.rsp_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();

    // T4: backpressure, 6 reads with no response consumption
    bus.rsp_ready = 1'b0;
    base = n_rd_hs;
    p0   = n_pop;
    fork
      begin
        for (int i = 0; i < 6; i++) do_req(1'b0, 5'($urandom), 32'd0);
        bus.req_valid = 1'b0;
      end
      begin
        repeat (12) @(negedge i_clk);
        chk("t4_accepted", 32'(n_rd_hs - base), 32'd4);
        chk("t4_ready", 32'(bus.req_ready), 32'd0);
        chk("t4_valid", 32'(bus.rsp_valid), 32'd1);
        @(posedge i_clk);
        #1 bus.rsp_ready = 1'b1;
      end
    join
    drain();
    chk("t4_pops", 32'(n_pop - p0), 32'd6);

    // T5: pop and read accept on the same edge at cnt=3
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) do_req(1'b0, 5'($urandom), 32'd0);
    idle(3);
    chk("t5_valid", 32'(bus.rsp_valid), 32'd1);
    p0 = n_pop;
    bus.rsp_ready = 1'b1;
    do_req(1'b0, 5'($urandom), 32'd0);
    bus.rsp_ready = 1'b0;
    do_req(1'b0, 5'($urandom), 32'd0);
    bus.req_valid = 1'b0;
    @(negedge i_clk);
    chk("t5_full", 32'(bus.req_ready), 32'd0);
    drain();
    chk("t5_pops", 32'(n_pop - p0), 32'd5);

    // T6: async reset with 3 reads in flight
    bus.rsp_ready = 1'b0;
    do_req(1'b0, 5'd5, 32'd0);
    do_req(1'b0, 5'd6, 32'd0);
    do_req(1'b0, 5'd7, 32'd0);
    bus.req_valid = 1'b0;
    i_rstn = 1'b0;
    #2;
    chk("t6_rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t6_rst_ready", 32'(bus.req_ready), 32'd0);
    @(posedge i_clk);
    @(posedge i_clk);
    #1 i_rstn = 1'b1;
    @(negedge i_clk);
    chk("t6_ready", 32'(bus.req_ready), 32'd1);
    chk("t6_valid", 32'(bus.rsp_valid), 32'd0);
    bus.rsp_ready = 1'b1;
    do_req(1'b0, 5'd3, 32'd0);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("t6_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("t6_rdata", bus.rsp_rdata, ref_mem[3]);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
